gate_sweep_sequencer: RTL

Clocked stimulus/capture stage that sits directly upstream of the custom_gate block (F = !C && (!A || B)). On START it steps {A,B,C} through all 8 input combinations, holding each for a programmable settle time. It samples the gate's F output into an 8-bit truth-table register and compares the result against an expected mask. This replaces hand-written #1 stimulus sequences with a synthesizable self-check.

---
 rtl/gate_sweep_sequencer_pkg.sv | 22 ++
 rtl/gate_sweep_sequencer_if.sv | 26 ++
 rtl/gate_sweep_sequencer_settle_timer.sv | 35 +++
 rtl/gate_sweep_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gate_sweep_sequencer_pkg.sv
// Shared definitions for the gate sweep sequencer.
// State encoding, sweep length and the custom_gate reference table.
package gate_sweep_sequencer_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam int VEC_COUNT = 8;

    // F = !C && (!A || B), bit index = {A,B,C}
    localparam logic [7:0] CUSTOM_GATE_TT = 8'h45;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETTLE = SETTLE,
        ST_SAMPLE = SAMPLE,
        ST_FINISH = FINISH
    } state_t;

endpackage

// File: rtl/gate_sweep_sequencer_if.sv
// Stimulus/capture bundle between the sequencer and its environment.
// master = sequencer side, slave = gate/controller side.
interface gate_sweep_sequencer_if;

    logic       START;
    logic       F_IN;
    logic       A;
    logic       B;
    logic       C;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [7:0] MISMATCH;
    logic       PASS;

    modport master (
        input  START, F_IN,
        output A, B, C, BUSY, DONE, RESULT, MISMATCH, PASS
    );

    modport slave (
        output START, F_IN,
        input  A, B, C, BUSY, DONE, RESULT, MISMATCH, PASS
    );

endinterface

// File: rtl/gate_sweep_sequencer_settle_timer.sv
// Per-vector settle counter for the gate sweep sequencer.
// Terminal count is raised once SETTLE_CYCLES cycles have been counted.
module sweep_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    logic [CW-1:0] r_cnt;

    // Restart on load, otherwise count up to the terminal value and hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/gate_sweep_sequencer.sv
// Steps {A,B,C} through all 8 vectors, captures F into a truth table
// and compares it against EXPECTED.
module gate_sweep_sequencer
    import gate_sweep_sequencer_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] EXPECTED      = CUSTOM_GATE_TT
) (
    input  logic CLK,
    input  logic RST_N,
    gate_sweep_sequencer_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [2:0] r_vec;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_result;
    logic [7:0] r_mismatch;
    logic       r_pass;

    logic       w_tc;
    logic       w_load;
    logic       w_en;
    logic       w_accept;
    logic       w_last;
    logic [7:0] w_result;

    assign w_accept = (r_state == ST_IDLE) && bus.START;
    assign w_last   = (r_idx == 3'(VEC_COUNT - 1));
    assign w_en     = (r_state == ST_SETTLE);
    assign w_load   = w_accept || (r_state == ST_SAMPLE);

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_load (w_load),
        .i_en   (w_en),
        .o_tc   (w_tc)
    );

    // Truth table including the bit being captured this cycle.
    always_comb begin
        w_result        = r_result;
        w_result[r_idx] = bus.F_IN;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.START) w_next = ST_SETTLE;
            ST_SETTLE: if (w_tc) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = w_last ? ST_FINISH : ST_SETTLE;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Stimulus vector, capture register and status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idx      <= '0;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mismatch <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_done <= (w_next == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (bus.START) begin
                        r_idx      <= '0;
                        r_vec      <= '0;
                        r_result   <= '0;
                        r_mismatch <= '0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_result <= w_result;
                    if (w_last) begin
                        r_mismatch <= w_result ^ EXPECTED;
                        r_pass     <= (w_result == EXPECTED);
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        r_vec <= r_idx + 3'd1;
                    end
                end
                ST_FINISH: begin
                    r_busy <= 1'b0;
                    r_vec  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.A        = r_vec[2];
    assign bus.B        = r_vec[1];
    assign bus.C        = r_vec[0];
    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;
    assign bus.RESULT   = r_result;
    assign bus.MISMATCH = r_mismatch;
    assign bus.PASS     = r_pass;

endmodule
